mem_wb_skid_reg: RTL and testbench
==================================

Name: mem_wb_skid_reg

Overview:
Parametrised MEM->WB pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
- Lets WB (or a multi-cycle register-file write port) back-pressure MEM without a combinational ready path.
- Supports a flush that squashes in-flight entries.
- Holds a NoP (bubble) marker and gates RegWEn for the forwarding unit.
- Keeps retire/bubble performance counters.

Parameters:
XLEN, 32, width of pc, ALU result and read-data fields
RD_W, 5, destination register index width
WBSEL_W, 2, write-back mux select width
CNT_W, 32, width of retire/bubble counters (wrap-around)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  squash all held entries (synchronous)
mem_valid  in  1  MEM presents an entry
mem_ready  out  1  stage can accept; registered, equals !skid_valid
mem_NoP_en  in  1  entry is a bubble
mem_RegWEn  in  1  entry writes register file
mem_rd  in  RD_W  destination register
mem_WBSel  in  WBSEL_W  write-back select
mem_pc  in  XLEN  pc
mem_ALU_out  in  XLEN  ALU result
mem_ReadData  in  XLEN  load data
wb_valid  out  1  main entry valid
wb_ready  in  1  WB consumes main entry this cycle
wb_NoP_en  out  1  bubble marker; 1 whenever !wb_valid
wb_RegWEn  out  1  mem_RegWEn of main entry AND wb_valid AND !wb_NoP_en
wb_rd, wb_WBSel, wb_pc, wb_ALU_out, wb_ReadData  out  per field  main entry payload
retire_cnt  out  CNT_W  non-NoP entries consumed
bubble_cnt  out  CNT_W  cycles with wb_ready=1 and (!wb_valid or wb_NoP_en)

Behaviour:
- Reset (async, rst=1):
  - main_valid=0, skid_valid=0, mem_ready=1.
  - All payload outputs 0; wb_NoP_en=1; wb_RegWEn=0.
  - Both counters 0.
- Events, evaluated at posedge:
  - accept = mem_valid & mem_ready.
  - consume = wb_valid & wb_ready.
- States (main_valid, skid_valid):
  - EMPTY(0,0).
  - ONE(1,0).
  - FULL(1,1); mem_ready=0 only here.
- Transitions:
  - EMPTY: accept -> ONE; payload into main; visible at wb_* next cycle (latency 1).
  - ONE, accept & consume: main <= incoming; stay ONE.
  - ONE, accept & !consume: incoming -> skid; go FULL.
  - ONE, !accept & consume: go EMPTY.
  - FULL, consume: main <= skid; skid cleared; go ONE. No accept is possible in FULL.
  - (0,1) is illegal and never reached.
- Ordering is strict FIFO. No entry is dropped or duplicated except by flush.
- mem_ready is a flop output. It depends on no input combinationally.
- Flush:
  - Next state EMPTY; mem_ready=1 next cycle.
  - Flush overrides a simultaneous accept (entry discarded) and a simultaneous consume (still counted if non-NoP, since WB sampled it).
  - Payload regs need not clear; wb_NoP_en forced 1 and wb_RegWEn forced 0 via !wb_valid.
- Output gating:
  - When !wb_valid, wb_NoP_en=1 and wb_RegWEn=0 regardless of stale payload.
  - The forwarding unit relies on wb_RegWEn alone.
- Counters:
  - retire_cnt += 1 on consume & !wb_NoP_en.
  - bubble_cnt += 1 on wb_ready & (!wb_valid | wb_NoP_en).
  - Both wrap modulo 2^CNT_W, no saturation.
  - Counters are not affected by flush.
- Reset mid-operation: immediate return to reset values regardless of state. Held entries are lost.
- Payload fields are stored verbatim, with no width conversion.

Test Plan:
- Reset release, wb_ready=1, then mem_valid=1 with rd=5, RegWEn=1, ALU_out=0x1234 -> wb_valid=1, wb_rd=5, wb_RegWEn=1, wb_ALU_out=0x1234 one cycle later; retire_cnt=1 after consume.
- wb_ready=0, push A (pc=0x100), B (pc=0x104) -> mem_ready=0 after B. Raise wb_ready -> wb_pc=0x100 then 0x104; mem_ready=1 the cycle after A consumed.
- Streaming 8 entries with wb_ready toggling 1,0,1,0 -> output pc sequence matches input order exactly; no loss or duplication.
- State FULL, assert flush with mem_valid=1 (pc=0x200) -> next cycle wb_valid=0, wb_NoP_en=1, wb_RegWEn=0, mem_ready=1; 0x200 never appears.
- Entry with mem_NoP_en=1, mem_RegWEn=1 -> wb_RegWEn=0; bubble_cnt increments; retire_cnt unchanged.
- CNT_W=4, retire 17 non-NoP entries -> retire_cnt=1 (wrap).
- Assert rst mid-stream in FULL -> outputs return asynchronously to reset values (wb_NoP_en=1, counters 0) before the next clock edge.

Source files
------------

// File: rtl/mem_wb_skid_reg.sv
// MEM->WB pipeline register with valid/ready handshake and a 2-entry skid buffer.
// mem_ready is a flop, so MEM never sees a combinational path from wb_ready.
module mem_wb_skid_reg #(
  parameter int XLEN    = 32,
  parameter int RD_W    = 5,
  parameter int WBSEL_W = 2,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               mem_valid,
  output logic               mem_ready,
  input  logic               mem_NoP_en,
  input  logic               mem_RegWEn,
  input  logic [RD_W-1:0]    mem_rd,
  input  logic [WBSEL_W-1:0] mem_WBSel,
  input  logic [XLEN-1:0]    mem_pc,
  input  logic [XLEN-1:0]    mem_ALU_out,
  input  logic [XLEN-1:0]    mem_ReadData,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic               wb_NoP_en,
  output logic               wb_RegWEn,
  output logic [RD_W-1:0]    wb_rd,
  output logic [WBSEL_W-1:0] wb_WBSel,
  output logic [XLEN-1:0]    wb_pc,
  output logic [XLEN-1:0]    wb_ALU_out,
  output logic [XLEN-1:0]    wb_ReadData,
  output logic [CNT_W-1:0]   retire_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  typedef struct packed {
    logic               nop;
    logic               regwen;
    logic [RD_W-1:0]    rd;
    logic [WBSEL_W-1:0] wbsel;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    alu;
    logic [XLEN-1:0]    rdata;
  } entry_t;

  entry_t           main_r;
  entry_t           skid_r;
  entry_t           main_nxt_s;
  entry_t           skid_nxt_s;
  entry_t           in_s;
  logic             main_valid_r;
  logic             skid_valid_r;
  logic             mem_ready_r;
  logic             main_valid_nxt_s;
  logic             skid_valid_nxt_s;
  logic             accept_s;
  logic             consume_s;
  logic             retire_s;
  logic             bubble_s;
  logic [CNT_W-1:0] retire_cnt_r;
  logic [CNT_W-1:0] bubble_cnt_r;

  // Pack the incoming MEM entry and derive handshake events.
  always_comb begin
    in_s.nop    = mem_NoP_en;
    in_s.regwen = mem_RegWEn;
    in_s.rd     = mem_rd;
    in_s.wbsel  = mem_WBSel;
    in_s.pc     = mem_pc;
    in_s.alu    = mem_ALU_out;
    in_s.rdata  = mem_ReadData;
    accept_s    = mem_valid & mem_ready_r;
    consume_s   = main_valid_r & wb_ready;
    retire_s    = consume_s & ~main_r.nop;
    bubble_s    = wb_ready & (~main_valid_r | main_r.nop);
  end

  // Next-state logic for the (main, skid) occupancy pair and payloads.
  always_comb begin
    main_nxt_s       = main_r;
    skid_nxt_s       = skid_r;
    main_valid_nxt_s = main_valid_r;
    skid_valid_nxt_s = skid_valid_r;
    if (flush) begin
      main_valid_nxt_s = 1'b0;
      skid_valid_nxt_s = 1'b0;
    end else begin
      case ({main_valid_r, skid_valid_r})
        2'b00: begin
          if (accept_s) begin
            main_nxt_s       = in_s;
            main_valid_nxt_s = 1'b1;
          end else begin
            main_valid_nxt_s = 1'b0;
          end
        end
        2'b10: begin
          if (accept_s && consume_s) begin
            main_nxt_s = in_s;
          end else if (accept_s) begin
            skid_nxt_s       = in_s;
            skid_valid_nxt_s = 1'b1;
          end else if (consume_s) begin
            main_valid_nxt_s = 1'b0;
          end else begin
            main_valid_nxt_s = 1'b1;
          end
        end
        2'b11: begin
          if (consume_s) begin
            main_nxt_s       = skid_r;
            skid_valid_nxt_s = 1'b0;
          end else begin
            skid_valid_nxt_s = 1'b1;
          end
        end
        // (0,1) cannot occur; fall back to empty if it ever does.
        default: begin
          main_valid_nxt_s = 1'b0;
          skid_valid_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // State, payload and ready registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_r       <= '0;
      skid_r       <= '0;
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      mem_ready_r  <= 1'b1;
    end else begin
      main_r       <= main_nxt_s;
      skid_r       <= skid_nxt_s;
      main_valid_r <= main_valid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      mem_ready_r  <= ~skid_valid_nxt_s;
    end
  end

  // Retire and bubble counters; wrap naturally and ignore flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt_r <= '0;
      bubble_cnt_r <= '0;
    end else begin
      if (retire_s) begin
        retire_cnt_r <= retire_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (bubble_s) begin
        bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Stale payload is masked by the valid bit so forwarding sees no write.
  assign mem_ready   = mem_ready_r;
  assign wb_valid    = main_valid_r;
  assign wb_NoP_en   = ~main_valid_r | main_r.nop;
  assign wb_RegWEn   = main_valid_r & ~main_r.nop & main_r.regwen;
  assign wb_rd       = main_r.rd;
  assign wb_WBSel    = main_r.wbsel;
  assign wb_pc       = main_r.pc;
  assign wb_ALU_out  = main_r.alu;
  assign wb_ReadData = main_r.rdata;
  assign retire_cnt  = retire_cnt_r;
  assign bubble_cnt  = bubble_cnt_r;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Directed bench for mem_wb_skid_reg (CNT_W=4 so counter wrap is reachable).
module tb_mem_wb_skid_reg;
  localparam int XLEN = 32, RD_W = 5, WBSEL_W = 2, CNT_W = 4;

  logic clk, rst, flush, mem_valid, mem_ready, mem_NoP_en, mem_RegWEn;
  logic [RD_W-1:0] mem_rd, wb_rd;
  logic [WBSEL_W-1:0] mem_WBSel, wb_WBSel;
  logic [XLEN-1:0] mem_pc, mem_ALU_out, mem_ReadData, wb_pc, wb_ALU_out, wb_ReadData;
  logic wb_valid, wb_ready, wb_NoP_en, wb_RegWEn;
  logic [CNT_W-1:0] retire_cnt, bubble_cnt;

  int errors = 0;
  int checks = 0;
  int sent;
  logic acc;
  logic [XLEN-1:0] got[$];

  mem_wb_skid_reg #(.XLEN(XLEN), .RD_W(RD_W), .WBSEL_W(WBSEL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_NoP_en(mem_NoP_en), .mem_RegWEn(mem_RegWEn), .mem_rd(mem_rd), .mem_WBSel(mem_WBSel),
    .mem_pc(mem_pc), .mem_ALU_out(mem_ALU_out), .mem_ReadData(mem_ReadData),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_NoP_en(wb_NoP_en), .wb_RegWEn(wb_RegWEn),
    .wb_rd(wb_rd), .wb_WBSel(wb_WBSel), .wb_pc(wb_pc), .wb_ALU_out(wb_ALU_out),
    .wb_ReadData(wb_ReadData), .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic nop, input logic we, input logic [31:0] pc);
    mem_valid  = v;
    mem_NoP_en = nop;
    mem_RegWEn = we;
    mem_pc     = pc;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wb_ready = 1'b0;
    mem_valid = 1'b0; mem_NoP_en = 1'b0; mem_RegWEn = 1'b0;
    mem_rd = '0; mem_WBSel = '0; mem_pc = '0; mem_ALU_out = '0; mem_ReadData = '0;
    #2;
    chk("rst_ready", 64'(mem_ready), 64'd1);
    chk("rst_valid", 64'(wb_valid), 64'd0);
    chk("rst_nop", 64'(wb_NoP_en), 64'd1);
    chk("rst_regwen", 64'(wb_RegWEn), 64'd0);
    chk("rst_pc", 64'(wb_pc), 64'd0);
    chk("rst_retire", 64'(retire_cnt), 64'd0);
    chk("rst_bubble", 64'(bubble_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic single transfer, latency 1
    wb_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 32'h10);
    mem_rd = 5'd5; mem_WBSel = 2'd1; mem_ALU_out = 32'h1234; mem_ReadData = 32'hdead;
    cyc();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t1_valid", 64'(wb_valid), 64'd1);
    chk("t1_rd", 64'(wb_rd), 64'd5);
    chk("t1_regwen", 64'(wb_RegWEn), 64'd1);
    chk("t1_alu", 64'(wb_ALU_out), 64'h1234);
    chk("t1_wbsel", 64'(wb_WBSel), 64'd1);
    chk("t1_rdata", 64'(wb_ReadData), 64'hdead);
    cyc();
    chk("t1_retire", 64'(retire_cnt), 64'd1);
    chk("t1_bubble", 64'(bubble_cnt), 64'd1);
    chk("t1_empty", 64'(wb_valid), 64'd0);

    // Back-pressure fills skid, then drains in order
    wb_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 32'h100); cyc();
    chk("t2_ready_one", 64'(mem_ready), 64'd1);
    drive(1'b1, 1'b0, 1'b1, 32'h104); cyc();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t2_ready_full", 64'(mem_ready), 64'd0);
    chk("t2_pc_a", 64'(wb_pc), 64'h100);
    wb_ready = 1'b1; cyc();
    chk("t2_pc_b", 64'(wb_pc), 64'h104);
    chk("t2_ready_back", 64'(mem_ready), 64'd1);
    cyc();
    chk("t2_drained", 64'(wb_valid), 64'd0);
    chk("t2_retire", 64'(retire_cnt), 64'd3);
    wb_ready = 1'b0;

    // Flush from FULL with a pending entry
    drive(1'b1, 1'b0, 1'b1, 32'h180); cyc();
    drive(1'b1, 1'b0, 1'b1, 32'h184); cyc();
    chk("t3_full", 64'(mem_ready), 64'd0);
    drive(1'b1, 1'b0, 1'b1, 32'h200); flush = 1'b1; cyc();
    chk("t3_valid", 64'(wb_valid), 64'd0);
    chk("t3_nop", 64'(wb_NoP_en), 64'd1);
    chk("t3_regwen", 64'(wb_RegWEn), 64'd0);
    chk("t3_ready", 64'(mem_ready), 64'd1);
    drive(1'b1, 1'b0, 1'b1, 32'h204); cyc();
    chk("t3_flush_acc", 64'(wb_valid), 64'd0);
    flush = 1'b0; drive(1'b0, 1'b0, 1'b0, 32'h0); cyc();
    chk("t3_no_200", 64'(wb_valid), 64'd0);

    // NoP entry gates RegWEn and counts as bubble
    drive(1'b1, 1'b1, 1'b1, 32'h300); cyc();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t4_valid", 64'(wb_valid), 64'd1);
    chk("t4_nop", 64'(wb_NoP_en), 64'd1);
    chk("t4_regwen", 64'(wb_RegWEn), 64'd0);
    wb_ready = 1'b1; cyc();
    wb_ready = 1'b0;
    chk("t4_retire", 64'(retire_cnt), 64'd3);
    chk("t4_bubble", 64'(bubble_cnt), 64'd2);

    // Streaming 8 entries with wb_ready toggling
    sent = 0;
    for (int k = 0; k < 17; k++) begin
      wb_ready  = (k % 2 == 0);
      mem_valid = (sent < 8);
      mem_RegWEn = 1'b1;
      mem_pc    = 32'h400 + 32'(4 * sent);
      acc = mem_valid && mem_ready;
      if (wb_valid && wb_ready) got.push_back(wb_pc);
      cyc();
      if (acc) sent++;
    end
    wb_ready = 1'b0; mem_valid = 1'b0;
    chk("t5_sent", 64'(sent), 64'd8);
    chk("t5_count", 64'(got.size()), 64'd8);
    for (int i = 0; i < got.size(); i++) chk("t5_order", 64'(got[i]), 64'h400 + 64'(4 * i));
    chk("t5_empty", 64'(wb_valid), 64'd0);
    chk("t5_retire", 64'(retire_cnt), 64'd11);
    chk("t5_bubble", 64'(bubble_cnt), 64'd3);

    // Async reset while FULL
    drive(1'b1, 1'b0, 1'b1, 32'h600); cyc();
    drive(1'b1, 1'b0, 1'b1, 32'h604); cyc();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t7_full", 64'(mem_ready), 64'd0);
    #1 rst = 1'b1;
    #1;
    chk("t7_valid", 64'(wb_valid), 64'd0);
    chk("t7_nop", 64'(wb_NoP_en), 64'd1);
    chk("t7_regwen", 64'(wb_RegWEn), 64'd0);
    chk("t7_ready", 64'(mem_ready), 64'd1);
    chk("t7_retire", 64'(retire_cnt), 64'd0);
    chk("t7_bubble", 64'(bubble_cnt), 64'd0);
    chk("t7_pc", 64'(wb_pc), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 17 retirements wrap a 4-bit counter to 1
    wb_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h500 + 32'(4 * i));
      cyc();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t6_last_pc", 64'(wb_pc), 64'h540);
    chk("t6_ready", 64'(mem_ready), 64'd1);
    cyc();
    chk("t6_retire_wrap", 64'(retire_cnt), 64'd1);
    chk("t6_bubble", 64'(bubble_cnt), 64'd1);
    cyc();
    chk("t6_bubble_idle", 64'(bubble_cnt), 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
